// File: rtl/muldiv_sequencer.sv
// Execute-stage sequencer for multi-cycle RV32M MUL*/DIV*/REM* operations.
// Define MULDIV_EARLY_OUT_EN to make a division by zero finish right after its accept cycle.
module muldiv_sequencer #(
   parameter int unsigned MUL_CYCLES = 3,
   parameter int unsigned DIV_CYCLES = 34
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       valid_e_i,
   input  logic [6:0] op_e_i,
   input  logic [2:0] funct3_e_i,
   input  logic [6:0] funct7_e_i,
   input  logic       flush_e_i,
   input  logic       div_zero_i,
   output logic       stall_o,
   output logic       md_start_o,
   output logic       md_done_o,
   output logic       md_abort_o,
   output logic [2:0] md_funct3_o,
   output logic       md_busy_o
);

   localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       funct3_q, funct3_d;
   logic             is_md_c, is_div_c, accept_c;
   logic             start_c, done_c, abort_c;

   // Gating with rst_n_i keeps start/stall low for the whole reset, not just after the flops clear.
   assign is_md_c  = (op_e_i == 7'b0110011) && (funct7_e_i == 7'b0000001);
   assign is_div_c = funct3_e_i[2];
   assign accept_c = rst_n_i && (state_q == S_IDLE) && valid_e_i && is_md_c && !flush_e_i;

`ifndef MULDIV_EARLY_OUT_EN
   logic unused_div_zero;
   assign unused_div_zero = div_zero_i;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         funct3_q <= 3'b000;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         funct3_q <= funct3_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      funct3_d = funct3_q;
      start_c  = 1'b0;
      done_c   = 1'b0;
      abort_c  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               start_c  = 1'b1;
               funct3_d = funct3_e_i;
               state_d  = S_BUSY;
               cnt_d    = is_div_c ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
`ifdef MULDIV_EARLY_OUT_EN
               if (is_div_c && div_zero_i) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
               end
`endif
            end
         end
         S_BUSY: begin
            // Flush wins over the final count transition.
            if (flush_e_i) begin
               abort_c = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (flush_e_i) begin
               abort_c = 1'b1;
               cnt_d   = '0;
            end else begin
               done_c = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign stall_o     = accept_c || (state_q == S_BUSY);
   assign md_start_o  = start_c;
   assign md_done_o   = done_c;
   assign md_abort_o  = abort_c;
   assign md_funct3_o = funct3_q;
   assign md_busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (MUL_CYCLES=3, DIV_CYCLES=34).
// Honours MULDIV_EARLY_OUT_EN for the divide-by-zero expectation.
module tb_muldiv_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_e;
   logic [6:0] op_e;
   logic [2:0] funct3_e;
   logic [6:0] funct7_e;
   logic       flush_e;
   logic       div_zero;
   logic       stall, md_start, md_done, md_abort, md_busy;
   logic [2:0] md_funct3;

   int checks = 0;
   int errors = 0;

   muldiv_sequencer #(.MUL_CYCLES(3), .DIV_CYCLES(34)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .valid_e_i  (valid_e),
      .op_e_i     (op_e),
      .funct3_e_i (funct3_e),
      .funct7_e_i (funct7_e),
      .flush_e_i  (flush_e),
      .div_zero_i (div_zero),
      .stall_o    (stall),
      .md_start_o (md_start),
      .md_done_o  (md_done),
      .md_abort_o (md_abort),
      .md_funct3_o(md_funct3),
      .md_busy_o  (md_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare every control output against the expected vector.
   task automatic check_all(input string tag, input logic e_stall, input logic e_start,
                            input logic e_done, input logic e_abort, input logic e_busy);
      check({tag, ".stall"}, 32'(stall), 32'(e_stall));
      check({tag, ".start"}, 32'(md_start), 32'(e_start));
      check({tag, ".done"}, 32'(md_done), 32'(e_done));
      check({tag, ".abort"}, 32'(md_abort), 32'(e_abort));
      check({tag, ".busy"}, 32'(md_busy), 32'(e_busy));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [6:0] f7, input logic [2:0] f3,
                        input logic fl, input logic dz);
      valid_e  = v;
      op_e     = 7'b0110011;
      funct7_e = f7;
      funct3_e = f3;
      flush_e  = fl;
      div_zero = dz;
   endtask

   // Hold an M instruction in E until its done cycle, then retire it and check the idle cycle after.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic dz, input int lat);
      drive(1'b1, 7'b0000001, f3, 1'b0, dz);
      for (int c = 0; c <= lat + 1; c++) begin
         if (c == lat + 1) valid_e = 1'b0;
         @(negedge clk);
         check_all($sformatf("%s.c%0d", tag, c), c < lat, c == 0, c == lat, 1'b0,
                   (c >= 1) && (c <= lat));
         if (c >= 1) check($sformatf("%s.c%0d.funct3", tag, c), 32'(md_funct3), 32'(f3));
         next_cycle();
      end
   endtask

   initial begin
      int div0_lat;
      rst_n = 1'b0;
      drive(1'b0, 7'b0000000, 3'b000, 1'b0, 1'b0);
      #2;
      check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.funct3", 32'(md_funct3), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();

      run_op("mul", 3'b000, 1'b0, 3);
      run_op("mulhu", 3'b011, 1'b0, 3);
      run_op("divu", 3'b101, 1'b0, 34);

      // Non-M and blocked M instructions must leave the sequencer idle.
      drive(1'b1, 7'b0000000, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      check_all("add", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 7'b0000001, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      check_all("mul_novalid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b1, 7'b0000001, 3'b000, 1'b1, 1'b0);
      @(negedge clk);
      check_all("mul_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 7'b0000000, 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      check_all("after_blocked", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      next_cycle();

      // DIV flushed mid-flight at cycle 10.
      drive(1'b1, 7'b0000001, 3'b100, 1'b0, 1'b0);
      for (int c = 0; c <= 40; c++) begin
         if (c == 10) flush_e = 1'b1;
         if (c == 11) begin
            flush_e = 1'b0;
            valid_e = 1'b0;
         end
         @(negedge clk);
         if (c == 0)
            check_all("divflush.c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         else if (c == 5 || c == 10)
            check_all($sformatf("divflush.c%0d", c), 1'b1, 1'b0, 1'b0, c == 10, 1'b1);
         else if (c >= 11)
            check({"divflush.done"}, 32'(md_done | md_busy | stall), 32'h0);
         next_cycle();
      end

      // MUL flushed in its DONE cycle: abort instead of done.
      drive(1'b1, 7'b0000001, 3'b001, 1'b0, 1'b0);
      for (int c = 0; c <= 4; c++) begin
         flush_e = (c == 3);
         if (c == 4) valid_e = 1'b0;
         @(negedge clk);
         if (c == 3) check_all("mulflushdone.c3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         if (c == 4) check_all("mulflushdone.c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         next_cycle();
      end
      flush_e = 1'b0;

      // Asynchronous reset during a DIV, instruction still presented.
      drive(1'b1, 7'b0000001, 3'b110, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) next_cycle();
      rst_n = 1'b0;
      #1;
      check_all("midreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("midreset.funct3", 32'(md_funct3), 32'h0);
      @(negedge clk);
      check_all("midreset.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      valid_e = 1'b0;
      rst_n   = 1'b1;
      next_cycle();
      run_op("mul_after_rst", 3'b010, 1'b0, 3);

`ifdef MULDIV_EARLY_OUT_EN
      div0_lat = 1;
`else
      div0_lat = 34;
`endif
      run_op("div_by_zero", 3'b100, 1'b1, div0_lat);
      run_op("rem", 3'b110, 1'b0, 34);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Execute-stage control sequencer for multi-cycle RV32M operations.
- Decodes op/funct3/funct7 of the E-stage instruction and detects MUL* and DIV*/REM*.
- Runs a per-class latency counter, stalls the pipeline until the result is due, and exposes start/done/abort handshakes to the datapath multiplier/divider.
- Sits beside the existing decode control path; the hazard unit ORs its stall into the global stall.

Parameters:
- MUL_CYCLES, 3: cycles from accept to done for funct3[2]=0 (MUL, MULH, MULHSU, MULHU). Must be >= 2.
- DIV_CYCLES, 34: cycles from accept to done for funct3[2]=1 (DIV, DIVU, REM, REMU). Must be >= 2.
- CNT_W, $clog2(max(MUL_CYCLES,DIV_CYCLES)+1): latency counter width. Derived; do not override.

Ports:
- clk_i, input, 1: clock.
- rst_n_i, input, 1: reset, asynchronous, active-low.
- valid_e_i, input, 1: E-stage holds a valid instruction.
- op_e_i, input, 7: E-stage opcode.
- funct3_e_i, input, 3: E-stage funct3.
- funct7_e_i, input, 7: E-stage funct7.
- flush_e_i, input, 1: E-stage flush (branch mispredict/trap).
- div_zero_i, input, 1: divisor operand is zero; used only with the optional feature.
- stall_o, output, 1: hold F/D/E stages.
- md_start_o, output, 1: one-cycle pulse; datapath latches operands.
- md_done_o, output, 1: one-cycle pulse; result valid, instruction advances.
- md_abort_o, output, 1: one-cycle pulse; in-flight operation cancelled.
- md_funct3_o, output, 3: funct3 latched at accept, held through DONE.
- md_busy_o, output, 1: state != IDLE.

Behaviour:
- Detection:
  - is_md = (op_e_i==7'b0110011) && (funct7_e_i==7'b0000001).
  - is_div = funct3_e_i[2].
  - accept = IDLE && valid_e_i && is_md && !flush_e_i.
- States: IDLE, BUSY, DONE. Encoding is free.
- IDLE:
  - On accept: md_start_o=1 (combinational, same cycle); latch md_funct3_o; cnt <= (is_div ? DIV_CYCLES : MUL_CYCLES) - 1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: if cnt==1, go to DONE; cnt <= cnt-1 every BUSY cycle.
- DONE: md_done_o=1, stall_o=0; next state is IDLE unconditionally. A new instruction cannot be accepted in DONE.
- stall_o = accept || (state==BUSY). Accept at cycle 0 gives done at cycle LAT and exactly LAT stall cycles.
- Flush:
  - flush_e_i in BUSY or DONE: md_abort_o=1 that cycle, next state IDLE, cnt<=0. No md_done_o.
  - Flush has priority over the cnt==1 transition.
  - flush_e_i in IDLE: blocks accept; no abort pulse.
- Non-M instructions, or valid_e_i=0: no state change, stall_o=0.
- Reset (rst_n_i low, any time, including mid-BUSY):
  - state=IDLE, cnt=0, md_funct3_o=3'b000.
  - All pulse, stall and busy outputs 0 immediately (combinational outputs depend on state only through reset flops).
- Counter never underflows: BUSY is entered only with cnt >= 1.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: accept of a division with div_zero_i=1 loads no count and goes directly to DONE. stall_o is high only in the accept cycle; md_done_o fires at cycle 1. The datapath supplies the RISC-V defined result (all-ones quotient / dividend remainder).
- Undefined: div_zero_i is ignored; divide by zero takes DIV_CYCLES like any division.

Test Plan (MUL_CYCLES=3, DIV_CYCLES=34):
- MUL (funct7=0000001, funct3=000, valid) at cycle 0 -> md_start_o pulses at 0; stall_o high at cycles 0-2; md_done_o at 3; md_funct3_o=000 at cycles 1-3; IDLE at 4.
- DIVU (funct3=101) at cycle 0 -> stall_o high for cycles 0-33; md_done_o at 34 only; md_busy_o high 1-34.
- DIV accepted at cycle 0, flush_e_i at cycle 10 -> md_abort_o at 10; stall_o=0 and md_busy_o=0 from 11; md_done_o never asserts.
- ADD (funct7=0000000) and MUL with valid_e_i=0 or flush_e_i=1 -> stall_o, md_start_o, md_busy_o remain 0.
- rst_n_i low at cycle 5 of a DIV -> all outputs 0 asynchronously; after release, a MUL completes normally in 3 cycles.
- With MULDIV_EARLY_OUT_EN: DIV with div_zero_i=1 -> stall_o only at cycle 0, md_done_o at 1. Without the macro: md_done_o at 34.
